// File: rtl/dht11_fmt_pkg.sv
// dht11_fmt_pkg: FSM states, frame lengths and ASCII constants shared by the DHT11 frame formatter.
package dht11_fmt_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, CONV_H, CONV_T, SEND} state_e;
  localparam int FRAME_LEN = 17;
  localparam int ERR_LEN = 5;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_0 = 8'h30;
  // Single decimal character; anything above 9 clamps to '9'.
  function automatic logic [7:0] dec_char(input logic [7:0] b);
    return (b > 8'd9) ? CH_0 + 8'd9 : CH_0 + b;
  endfunction
endpackage

// File: rtl/dht11_bin2bcd8.sv
// dht11_bin2bcd8: 8-bit binary to 3-digit BCD, shift-add-3, 8 cycles per conversion, done pulse after.
module dht11_bin2bcd8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        done_o
);
  logic [7:0] sr_q, sr_base;
  logic [11:0] bcd_q, base, adj;
  logic [2:0] cnt_q;
  logic run_q, done_q;
  logic [19:0] shifted;
  // The start cycle already performs the first shift, so 8 cycles cover all 8 bits.
  always_comb begin
    base = start_i ? 12'd0 : bcd_q;
    sr_base = start_i ? bin_i : sr_q;
    adj = base;
    for (int k = 0; k < 3; k++)
      adj[4*k +: 4] = (base[4*k +: 4] > 4'd4) ? base[4*k +: 4] + 4'd3 : base[4*k +: 4];
    shifted = {adj, sr_base} << 1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= run_q && !start_i && cnt_q == 3'd7;
      if (start_i || run_q) begin
        bcd_q <= shifted[19:8];
        sr_q <= shifted[7:0];
        cnt_q <= start_i ? 3'd1 : cnt_q + 3'd1;
        run_q <= start_i || cnt_q != 3'd7;
      end
    end
  end
  assign bcd_o = bcd_q;
  assign done_o = done_q;
endmodule

// File: rtl/dht11_frame_formatter.sv
// dht11_frame_formatter: turns a DHT11 reading into "H=hhh.d T=ttt.d\r\n" for a UART byte stream.
// Define DHT11_FMT_CKSUM_EN to verify the checksum and send "ERR\r\n" on mismatch.
module dht11_frame_formatter
  import dht11_fmt_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        hum_int,
  input  logic [7:0]        hum_dec,
  input  logic [7:0]        tem_int,
  input  logic [7:0]        tem_dec,
  input  logic [7:0]        checksum,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] hi_q, hi_d, hd_q, hd_d, ti_q, ti_d, td_q, td_d;
  logic [11:0] hbcd_q, hbcd_d, tbcd_q, tbcd_d;
  logic err_q, err_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic conv_start, conv_done, last;
  logic [11:0] conv_bcd;
  logic [7:0] byte_c;
`ifdef DHT11_FMT_CKSUM_EN
  logic [7:0] cks_q, cks_d, sum;
  assign sum = hi_q + hd_q + ti_q + td_q;
`else
  logic unused_cksum;
  assign unused_cksum = ^checksum;
`endif
  dht11_bin2bcd8 u_conv (
    .clk(clk),
    .reset(reset),
    .start_i(conv_start),
    .bin_i(state_q == CAPTURE ? hi_q : ti_q),
    .bcd_o(conv_bcd),
    .done_o(conv_done)
  );
  assign last = idx_q == (err_q ? 5'(ERR_LEN - 1) : 5'(FRAME_LEN - 1));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    hi_d = hi_q;
    hd_d = hd_q;
    ti_d = ti_q;
    td_d = td_q;
    hbcd_d = hbcd_q;
    tbcd_d = tbcd_q;
    err_d = err_q;
    drop_d = drop_q;
    conv_start = 1'b0;
`ifdef DHT11_FMT_CKSUM_EN
    cks_d = cks_q;
`endif
    if (wr_en && state_q != IDLE && drop_q != '1) drop_d = drop_q + DROP_W'(1);
    case (state_q)
      IDLE: if (wr_en) begin
        hi_d = hum_int;
        hd_d = hum_dec;
        ti_d = tem_int;
        td_d = tem_dec;
`ifdef DHT11_FMT_CKSUM_EN
        cks_d = checksum;
`endif
        err_d = 1'b0;
        idx_d = 5'd0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
`ifdef DHT11_FMT_CKSUM_EN
        err_d = cks_q != sum;
        conv_start = cks_q == sum;
        state_d = (cks_q == sum) ? CONV_H : SEND;
`else
        conv_start = 1'b1;
        state_d = CONV_H;
`endif
      end
      // Humidity result lands the same cycle the converter is restarted on temperature.
      CONV_H: if (conv_done) begin
        hbcd_d = conv_bcd;
        conv_start = 1'b1;
        state_d = CONV_T;
      end
      CONV_T: if (conv_done) begin
        tbcd_d = conv_bcd;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        idx_d = idx_q + 5'd1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    byte_c = 8'h00;
    if (err_q)
      case (idx_q)
        5'd0: byte_c = CH_E;
        5'd1: byte_c = CH_R;
        5'd2: byte_c = CH_R;
        5'd3: byte_c = CH_CR;
        5'd4: byte_c = CH_LF;
        default: byte_c = 8'h00;
      endcase
    else
      case (idx_q)
        5'd0: byte_c = CH_H;
        5'd1: byte_c = CH_EQ;
        5'd2: byte_c = dec_char({4'd0, hbcd_q[11:8]});
        5'd3: byte_c = dec_char({4'd0, hbcd_q[7:4]});
        5'd4: byte_c = dec_char({4'd0, hbcd_q[3:0]});
        5'd5: byte_c = CH_DOT;
        5'd6: byte_c = dec_char(hd_q);
        5'd7: byte_c = CH_SP;
        5'd8: byte_c = CH_T;
        5'd9: byte_c = CH_EQ;
        5'd10: byte_c = dec_char({4'd0, tbcd_q[11:8]});
        5'd11: byte_c = dec_char({4'd0, tbcd_q[7:4]});
        5'd12: byte_c = dec_char({4'd0, tbcd_q[3:0]});
        5'd13: byte_c = CH_DOT;
        5'd14: byte_c = dec_char(td_q);
        5'd15: byte_c = CH_CR;
        5'd16: byte_c = CH_LF;
        default: byte_c = 8'h00;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      hi_q <= '0;
      hd_q <= '0;
      ti_q <= '0;
      td_q <= '0;
      hbcd_q <= '0;
      tbcd_q <= '0;
      err_q <= 1'b0;
      drop_q <= '0;
`ifdef DHT11_FMT_CKSUM_EN
      cks_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      hi_q <= hi_d;
      hd_q <= hd_d;
      ti_q <= ti_d;
      td_q <= td_d;
      hbcd_q <= hbcd_d;
      tbcd_q <= tbcd_d;
      err_q <= err_d;
      drop_q <= drop_d;
`ifdef DHT11_FMT_CKSUM_EN
      cks_q <= cks_d;
`endif
    end
  end
  // Valid is a pure state decode, so reset drops it without waiting for a clock.
  assign tx_valid = state_q == SEND;
  assign tx_data = tx_valid ? byte_c : 8'h00;
  assign busy = state_q != IDLE;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_dht11_frame_formatter.sv
// tb_dht11_frame_formatter: directed frames, stalls, drops and mid-frame reset for dht11_frame_formatter.
module tb_dht11_frame_formatter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0;
  logic tx_ready = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, tem_int = '0, tem_dec = '0, checksum = '0;
  logic [7:0] tx_data;
  logic tx_valid, busy;
  logic [7:0] drop_cnt;
  int total = 0;
  int bad = 0;
  localparam string NORM = "H=045.0 T=023.5\r\n";
  always #5 clk = ~clk;
  dht11_frame_formatter #(.DROP_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .hum_int(hum_int),
    .hum_dec(hum_dec),
    .tem_int(tem_int),
    .tem_dec(tem_dec),
    .checksum(checksum),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                       input logic [7:0] td, input logic [7:0] ck);
    hum_int = hi;
    hum_dec = hd;
    tem_int = ti;
    tem_dec = td;
    checksum = ck;
    wr_en = 1'b1;
    tick;
    wr_en = 1'b0;
    hum_int = 8'($urandom);
    hum_dec = 8'($urandom);
    tem_int = 8'($urandom);
    tem_dec = 8'($urandom);
    checksum = 8'($urandom);
    chk("busy_after_wr", busy, 1);
  endtask
  task automatic collect(input string s, input int mode, input int drop_at, input bit chk_lat,
                         input bit chk_end);
    int got = 0;
    int cyc = 0;
    bit stalled = 0, seen = 0, dropped = 0;
    logic [7:0] held = '0;
    while (got < s.len() && cyc < 400) begin
      tx_ready = (mode == 0) || (cyc % 3 == 0);
      wr_en = (got == drop_at) && !dropped;
      if (wr_en) dropped = 1;
      if (tx_valid) begin
        if (!seen && chk_lat) chk("first_valid_le20", 32'(cyc + 1 <= 20), 1);
        seen = 1;
        if (stalled) chk("stall_hold", tx_data, held);
        if (tx_ready) begin
          chk($sformatf("byte%0d", got), tx_data, 8'(s[got]));
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = tx_data;
        end
      end
      tick;
      cyc++;
    end
    wr_en = 1'b0;
    tx_ready = 1'b0;
    chk("byte_count", got, s.len());
    if (chk_end) begin
      chk("busy_end", busy, 0);
      chk("valid_end", tx_valid, 0);
    end
  endtask
  initial begin
    int vcount;
    tick;
    tick;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b1;
    tick;
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd73);
    collect(NORM, 0, -1, 1, 1);
    start(8'd255, 8'd12, 8'd0, 8'd0, 8'd11);
    collect("H=255.9 T=000.0\r\n", 0, -1, 1, 1);
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd73);
    collect(NORM, 1, -1, 1, 1);
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd0);
`ifdef DHT11_FMT_CKSUM_EN
    collect("ERR\r\n", 0, -1, 1, 1);
`else
    collect(NORM, 0, -1, 1, 1);
`endif
    chk("drop_none", drop_cnt, 0);
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd73);
    collect(NORM, 0, 5, 1, 1);
    chk("drop_one", drop_cnt, 1);
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd73);
    wr_en = 1'b1;
    tx_ready = 1'b0;
    repeat (300) tick;
    wr_en = 1'b0;
    chk("drop_sat", drop_cnt, 255);
    chk("busy_stalled", busy, 1);
    collect(NORM, 0, -1, 0, 1);
    chk("drop_sat_hold", drop_cnt, 255);
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd73);
    collect("H=045.0 ", 0, -1, 1, 0);
    chk("pre_reset_valid", tx_valid, 1);
    reset = 1'b0;
    #1;
    chk("midrst_valid", tx_valid, 0);
    chk("midrst_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_drop", drop_cnt, 0);
    tick;
    reset = 1'b1;
    vcount = 0;
    repeat (30) begin
      tick;
      if (tx_valid) vcount++;
    end
    chk("no_output_after_rst", vcount, 0);
    chk("idle_after_rst", busy, 0);
    start(8'd45, 8'd0, 8'd23, 8'd5, 8'd73);
    collect(NORM, 0, -1, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
